// File: rtl/i_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface i_fetch_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic [AW-1:0] IMemAddr;
  logic          IMemRd;
  logic [DW-1:0] IMemData;
  logic          IMemDone;

  modport master (output IMemAddr, IMemRd, input IMemData, IMemDone);
  modport slave  (input IMemAddr, IMemRd, output IMemData, IMemDone);
endinterface

// File: rtl/i_fetch.sv
// Instruction fetch stage: PC, variable-latency imem requests, one-entry skid, F/D register.
// Optional macro IFETCH_ALIGN_ERR_EN: a misaligned redirect raises sticky err and halts fetch.
module i_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_D,
  input  logic        DataMemStall,
  input  logic        Redirect_E,
  input  logic [15:0] Target_E,
  input  logic        Halt_D,
  i_fetch_if.master   imem,
  output logic [15:0] Inst_F,
  output logic [15:0] PCInc_F,
  output logic        Inst_F_Valid,
  output logic        Halted,
  output logic        err
);
  localparam int unsigned XW = 16;

  typedef enum logic [1:0] {REQ, BUF, DRAIN, HALTED} stateT;

  stateT         state, stateNxt;
  logic [XW-1:0] pc, pcNxt, pcPlus2;
  logic [XW-1:0] skidInst, skidInstNxt, skidPcInc, skidPcIncNxt;
  logic [XW-1:0] pendTarget, pendTargetNxt;
  logic          pendHalt, pendHaltNxt;
  logic [XW-1:0] instNxt, pcIncNxt;
  logic          validNxt, errNxt;
  logic          hold, redirEff, haltEff, misAlign, done;
  logic [XW-1:0] tgt;

  assign hold     = Stall_D | DataMemStall;
  assign redirEff = Redirect_E & ~DataMemStall;
  assign haltEff  = Halt_D & ~hold & ~Redirect_E;
  assign done     = imem.IMemDone;
  assign pcPlus2  = pc + XW'(2);
  assign imem.IMemAddr = pc;

`ifdef IFETCH_ALIGN_ERR_EN
  assign tgt      = Target_E;
  assign misAlign = Target_E[0];
`else
  assign tgt      = Target_E & 16'hFFFE;
  assign misAlign = 1'b0;
`endif

  // Next-state and F/D update; redirect beats halt beats normal flow.
  always_comb begin
    stateNxt      = state;
    pcNxt         = pc;
    skidInstNxt   = skidInst;
    skidPcIncNxt  = skidPcInc;
    pendTargetNxt = pendTarget;
    pendHaltNxt   = pendHalt;
    instNxt       = Inst_F;
    pcIncNxt      = PCInc_F;
    validNxt      = Inst_F_Valid;
    errNxt        = err;

    case (state)
      REQ: begin
        if (redirEff) begin
          validNxt = 1'b0;
          if (misAlign) begin
            errNxt = 1'b1;
            if (done) stateNxt = HALTED;
            else begin
              pendHaltNxt = 1'b1;
              stateNxt    = DRAIN;
            end
          end else if (done) begin
            pcNxt = tgt;
          end else begin
            pendTargetNxt = tgt;
            pendHaltNxt   = 1'b0;
            stateNxt      = DRAIN;
          end
        end else if (haltEff) begin
          validNxt = 1'b0;
          if (done) stateNxt = HALTED;
          else begin
            pendHaltNxt = 1'b1;
            stateNxt    = DRAIN;
          end
        end else if (done) begin
          pcNxt = pcPlus2;
          if (hold) begin
            skidInstNxt  = imem.IMemData;
            skidPcIncNxt = pcPlus2;
            stateNxt     = BUF;
          end else begin
            instNxt  = imem.IMemData;
            pcIncNxt = pcPlus2;
            validNxt = 1'b1;
          end
        end else if (!hold) begin
          validNxt = 1'b0;
        end
      end
      BUF: begin
        if (redirEff) begin
          validNxt = 1'b0;
          if (misAlign) begin
            errNxt   = 1'b1;
            stateNxt = HALTED;
          end else begin
            pcNxt    = tgt;
            stateNxt = REQ;
          end
        end else if (haltEff) begin
          validNxt = 1'b0;
          stateNxt = HALTED;
        end else if (!hold) begin
          instNxt  = skidInst;
          pcIncNxt = skidPcInc;
          validNxt = 1'b1;
          stateNxt = REQ;
        end
      end
      DRAIN: begin
        if (redirEff) begin
          validNxt    = 1'b0;
          pendHaltNxt = misAlign;
          if (misAlign) errNxt = 1'b1;
          else pendTargetNxt = tgt;
        end
        // Outstanding data is dropped; the pending action decides where to go.
        if (done) begin
          if (pendHaltNxt) stateNxt = HALTED;
          else begin
            pcNxt    = pendTargetNxt;
            stateNxt = REQ;
          end
          pendHaltNxt = 1'b0;
        end
      end
      HALTED: stateNxt = HALTED;
      default: stateNxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= REQ;
      pc           <= RESET_PC;
      skidInst     <= '0;
      skidPcInc    <= '0;
      pendTarget   <= '0;
      pendHalt     <= 1'b0;
      Inst_F       <= NOP_INST;
      PCInc_F      <= '0;
      Inst_F_Valid <= 1'b0;
      Halted       <= 1'b0;
      err          <= 1'b0;
      imem.IMemRd  <= 1'b1;
    end else begin
      state        <= stateNxt;
      pc           <= pcNxt;
      skidInst     <= skidInstNxt;
      skidPcInc    <= skidPcIncNxt;
      pendTarget   <= pendTargetNxt;
      pendHalt     <= pendHaltNxt;
      Inst_F       <= validNxt ? instNxt : NOP_INST;
      PCInc_F      <= pcIncNxt;
      Inst_F_Valid <= validNxt;
      Halted       <= (stateNxt == HALTED);
      err          <= errNxt;
      imem.IMemRd  <= (stateNxt == REQ) || (stateNxt == DRAIN);
    end
  end
endmodule

// File: tb/tb_i_fetch.sv
// Bench for i_fetch: directed vector table, then random traffic against a reference model.
module tb_i_fetch;
  localparam logic [15:0] NOP = 16'h0800;
`ifdef IFETCH_ALIGN_ERR_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, Stall_D, DataMemStall, Redirect_E, Halt_D;
  logic [15:0] Target_E;
  logic [15:0] Inst_F, PCInc_F;
  logic        Inst_F_Valid, Halted, err;

  i_fetch_if bus ();

  i_fetch dut (
    .clk(clk), .rst(rst), .Stall_D(Stall_D), .DataMemStall(DataMemStall),
    .Redirect_E(Redirect_E), .Target_E(Target_E), .Halt_D(Halt_D), .imem(bus),
    .Inst_F(Inst_F), .PCInc_F(PCInc_F), .Inst_F_Valid(Inst_F_Valid),
    .Halted(Halted), .err(err)
  );

  typedef struct {
    bit rst, stall, dms, redir;
    logic [15:0] tgt;
    bit halt, done;
    logic [15:0] data;
    bit eRd;
    logic [15:0] eAddr, eInst, ePcInc;
    bit eValid, eHalted, eErr;
  } vecT;

  int nVec = 0;
  int nMis = 0;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vecT v);
    rst = v.rst; Stall_D = v.stall; DataMemStall = v.dms; Redirect_E = v.redir;
    Target_E = v.tgt; Halt_D = v.halt; bus.IMemDone = v.done; bus.IMemData = v.data;
  endtask

  task automatic checkOut(input string tag, input int idx, input vecT v);
    chk({tag, ".IMemRd"}, idx, 16'(bus.IMemRd), 16'(v.eRd));
    if (v.eRd) chk({tag, ".IMemAddr"}, idx, bus.IMemAddr, v.eAddr);
    chk({tag, ".Inst_F"}, idx, Inst_F, v.eInst);
    chk({tag, ".PCInc_F"}, idx, PCInc_F, v.ePcInc);
    chk({tag, ".Valid"}, idx, 16'(Inst_F_Valid), 16'(v.eValid));
    chk({tag, ".Halted"}, idx, 16'(Halted), 16'(v.eHalted));
    chk({tag, ".err"}, idx, 16'(err), 16'(v.eErr));
  endtask

  function automatic vecT mkV(bit r, bit st, bit dm, bit rd, logic [15:0] tg, bit hl, bit dn,
                              logic [15:0] dt, bit eRd, logic [15:0] eAddr, logic [15:0] eInst,
                              logic [15:0] ePcInc, bit eValid, bit eHalted, bit eErr);
    vecT v;
    v.rst = r; v.stall = st; v.dms = dm; v.redir = rd; v.tgt = tg; v.halt = hl; v.done = dn;
    v.data = dt; v.eRd = eRd; v.eAddr = eAddr; v.eInst = eInst; v.ePcInc = ePcInc;
    v.eValid = eValid; v.eHalted = eHalted; v.eErr = eErr;
    return v;
  endfunction

  // Reference model: fetch PC, a skid queue, a pending drain action and the F/D slot.
  logic [15:0] mPc, mFdInst, mFdPc;
  bit          mFdValid, mHalted, mErr;
  int          mDrain;            // -1 nothing outstanding to drain, -2 halt after drain, else target
  logic [31:0] skidQ[$];

  task automatic modelReset();
    mPc = 16'h0000; mFdInst = 16'h0; mFdPc = 16'h0; mFdValid = 1'b0;
    mHalted = 1'b0; mErr = 1'b0; mDrain = -1; skidQ.delete();
  endtask

  function automatic bit modelRd();
    return !mHalted && skidQ.size() == 0;
  endfunction

  task automatic modelStep(input vecT v);
    bit hold, redir, haltE, bad;
    logic [15:0] tg;
    logic [31:0] e;
    hold  = v.stall | v.dms;
    redir = v.redir & ~v.dms;
    haltE = v.halt & ~hold & ~v.redir;
    bad   = ALIGN && v.tgt[0];
    tg    = ALIGN ? v.tgt : (v.tgt & 16'hFFFE);
    if (mHalted) return;
    if (mDrain != -1) begin
      if (redir) begin
        mFdValid = 1'b0;
        mDrain = bad ? -2 : int'(tg);
        if (bad) mErr = 1'b1;
      end
      if (v.done) begin
        if (mDrain == -2) mHalted = 1'b1;
        else mPc = 16'(mDrain);
        mDrain = -1;
      end
    end else if (skidQ.size() != 0) begin
      if (redir) begin
        skidQ.delete(); mFdValid = 1'b0;
        if (bad) begin mErr = 1'b1; mHalted = 1'b1; end
        else mPc = tg;
      end else if (haltE) begin
        skidQ.delete(); mFdValid = 1'b0; mHalted = 1'b1;
      end else if (!hold) begin
        e = skidQ.pop_front();
        mFdInst = e[31:16]; mFdPc = e[15:0]; mFdValid = 1'b1;
      end
    end else begin
      if (redir) begin
        mFdValid = 1'b0;
        if (bad) mErr = 1'b1;
        if (v.done) begin
          if (bad) mHalted = 1'b1;
          else mPc = tg;
        end else mDrain = bad ? -2 : int'(tg);
      end else if (haltE) begin
        mFdValid = 1'b0;
        if (v.done) mHalted = 1'b1;
        else mDrain = -2;
      end else if (v.done) begin
        if (hold) skidQ.push_back({v.data, mPc + 16'd2});
        else begin
          mFdInst = v.data; mFdPc = mPc + 16'd2; mFdValid = 1'b1;
        end
        mPc = mPc + 16'd2;
      end else if (!hold) mFdValid = 1'b0;
    end
  endtask

  function automatic vecT modelExp(input vecT v);
    vecT r = v;
    r.eRd = modelRd(); r.eAddr = mPc;
    r.eInst = mFdValid ? mFdInst : NOP; r.ePcInc = mFdPc;
    r.eValid = mFdValid; r.eHalted = mHalted; r.eErr = mErr;
    return r;
  endfunction

  vecT tbl[$];
  vecT rv;
  vecT rst0;

  initial begin
    rst0 = mkV(1,0,0,0,16'h0,0,0,16'h0, 1,16'h0000,NOP,16'h0000,0,0,0);
    tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h4001, 1,16'h0002,16'h4001,16'h0002,1,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h4002, 1,16'h0004,16'h4002,16'h0004,1,0,0));
    tbl.push_back(rst0);
    tbl.push_back(mkV(0,0,0,0,16'h0,0,0,16'h0, 1,16'h0000,NOP,16'h0000,0,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,0,16'h0, 1,16'h0000,NOP,16'h0000,0,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h5000, 1,16'h0002,16'h5000,16'h0002,1,0,0));
    tbl.push_back(mkV(0,1,0,0,16'h0,0,1,16'h6000, 0,16'h0000,16'h5000,16'h0002,1,0,0));
    tbl.push_back(mkV(0,1,0,0,16'h0,0,0,16'h0, 0,16'h0000,16'h5000,16'h0002,1,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,0,16'h0, 1,16'h0004,16'h6000,16'h0004,1,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h6001, 1,16'h0006,16'h6001,16'h0006,1,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,0,16'h0, 1,16'h0006,NOP,16'h0006,0,0,0));
    tbl.push_back(mkV(0,0,0,1,16'h0040,0,0,16'h0, 1,16'h0006,NOP,16'h0006,0,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,0,16'h0, 1,16'h0006,NOP,16'h0006,0,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h7777, 1,16'h0040,NOP,16'h0006,0,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h7000, 1,16'h0042,16'h7000,16'h0042,1,0,0));
    tbl.push_back(mkV(0,0,0,1,16'h0080,0,1,16'h1234, 1,16'h0080,NOP,16'h0042,0,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h8000, 1,16'h0082,16'h8000,16'h0082,1,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,1,1,16'h9999, 0,16'h0000,NOP,16'h0082,0,1,0));
    tbl.push_back(mkV(0,0,0,1,16'h0100,0,0,16'h0, 0,16'h0000,NOP,16'h0082,0,1,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,0,16'h0, 0,16'h0000,NOP,16'h0082,0,1,0));
    tbl.push_back(rst0);
    tbl.push_back(mkV(0,0,0,1,16'hFFFE,0,1,16'h0111, 1,16'hFFFE,NOP,16'h0000,0,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h0ABC, 1,16'h0000,16'h0ABC,16'h0000,1,0,0));
    if (ALIGN) begin
      tbl.push_back(mkV(0,0,0,1,16'h0031,0,1,16'h0222, 0,16'h0000,NOP,16'h0000,0,1,1));
      tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h0321, 0,16'h0000,NOP,16'h0000,0,1,1));
      tbl.push_back(mkV(0,0,1,1,16'h0100,0,0,16'h0, 0,16'h0000,NOP,16'h0000,0,1,1));
    end else begin
      tbl.push_back(mkV(0,0,0,1,16'h0031,0,1,16'h0222, 1,16'h0030,NOP,16'h0000,0,0,0));
      tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h0321, 1,16'h0032,16'h0321,16'h0032,1,0,0));
      tbl.push_back(mkV(0,0,1,1,16'h0100,0,0,16'h0, 1,16'h0032,16'h0321,16'h0032,1,0,0));
    end
    tbl.push_back(rst0);
    tbl.push_back(mkV(0,0,0,0,16'h0,1,0,16'h0, 1,16'h0000,NOP,16'h0000,0,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h3333, 0,16'h0000,NOP,16'h0000,0,1,0));
    // Redirect during drain retargets; redirect beats halt; stall blocks halt.
    tbl.push_back(rst0);
    tbl.push_back(mkV(0,0,0,0,16'h0,0,0,16'h0, 1,16'h0000,NOP,16'h0000,0,0,0));
    tbl.push_back(mkV(0,0,0,1,16'h0010,0,0,16'h0, 1,16'h0000,NOP,16'h0000,0,0,0));
    tbl.push_back(mkV(0,1,0,1,16'h0020,0,0,16'h0, 1,16'h0000,NOP,16'h0000,0,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h5555, 1,16'h0020,NOP,16'h0000,0,0,0));
    tbl.push_back(mkV(0,0,0,0,16'h0,0,1,16'h2222, 1,16'h0022,16'h2222,16'h0022,1,0,0));
    tbl.push_back(mkV(0,1,0,0,16'h0,1,0,16'h0, 1,16'h0022,16'h2222,16'h0022,1,0,0));
    tbl.push_back(mkV(0,0,0,1,16'h0060,1,1,16'h4444, 1,16'h0060,NOP,16'h0022,0,0,0));

    drive(rst0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    checkOut("reset", 0, rst0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk); @(negedge clk);
      checkOut("vec", i, tbl[i]);
    end

    modelReset();
    drive(rst0);
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      rv = rst0;
      rv.rst   = ($urandom_range(0, 199) == 0) || (mHalted && $urandom_range(0, 7) == 0);
      rv.stall = ($urandom_range(0, 3) == 0);
      rv.dms   = ($urandom_range(0, 9) == 0);
      rv.redir = ($urandom_range(0, 11) == 0);
      rv.tgt   = 16'($urandom) & (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'hFFFE);
      rv.halt  = ($urandom_range(0, 24) == 0);
      rv.done  = modelRd() && ($urandom_range(0, 2) != 0);
      rv.data  = 16'($urandom);
      drive(rv);
      if (rv.rst) modelReset();
      else modelStep(rv);
      @(posedge clk); @(negedge clk);
      checkOut("rand", c, modelExp(rv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
